// File: rtl/shifter_pkg.sv
// Shared op codes and FSM state encoding for the iterative shifter.
package shifter_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational one-step shifter: moves data by k (0..STEP) positions per op.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       op,
  input  logic             fill,
  output logic [WIDTH-1:0] res
);

  logic [2*WIDTH-1:0] wide;

  always_comb begin
    wide = '0;
    res  = data;
    case (op)
      SH_SLL: res = data << k;
      SH_SRL: res = data >> k;
      SH_SRA: begin
        wide = {{WIDTH{fill}}, data} >> k;
        res  = wide[WIDTH-1:0];
      end
      default: begin
        wide = {data, data} >> k;
        res  = wide[WIDTH-1:0];
      end
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROR shifter advancing up to STEP bits per clock,
// with valid/ready handshakes on the request and result sides.
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int AMTW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMTW-1:0]  in_amt,
  input  logic [1:0]       in_op,
  input  logic             flush,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int KW = $clog2(STEP + 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [1:0]        op_q, op_d;
  logic              fill_q, fill_d;
  logic [AMTW-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic [WIDTH-1:0]  step_data, step_res;
  logic [1:0]        step_op;
  logic              step_fill;
  logic [AMTW-1:0]   rem_src, rem_nxt;
  logic [KW-1:0]     k;

  // The first step is applied in the accept cycle straight from the inputs,
  // so a request of amt<=STEP completes with a single-cycle latency.
  always_comb begin
    if (state_q == ST_IDLE) begin
      step_data = in_data;
      step_op   = in_op;
      step_fill = (in_op == SH_SRA) && in_data[WIDTH-1];
      rem_src   = in_amt;
    end else begin
      step_data = data_q;
      step_op   = op_q;
      step_fill = fill_q;
      rem_src   = rem_q;
    end
    if (int'(rem_src) < STEP) k = KW'(rem_src);
    else                      k = KW'(STEP);
    rem_nxt = rem_src - AMTW'(k);
  end

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .data (step_data),
    .k    (k),
    .op   (step_op),
    .fill (step_fill),
    .res  (step_res)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    op_d        = op_q;
    fill_d      = fill_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d = step_res;
          op_d   = step_op;
          fill_d = step_fill;
          rem_d  = rem_nxt;
          if (rem_nxt == '0) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            out_data_d  = step_res;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d = step_res;
        rem_d  = rem_nxt;
        if (rem_nxt == '0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_data_d  = step_res;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    // Abort wins over both accept and the output handshake; result is kept.
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      op_q        <= SH_SLL;
      fill_q      <= 1'b0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      op_q        <= op_d;
      fill_q      <= fill_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
